// File: rtl/logicgates_bist_pkg.sv
// Shared types and constants for the logic-gate unit self-test sequencer.
// The truth table here is cross-checked against the equation-based golden model.
package logicgates_pkg;

  localparam int Y_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int Y_NOT  = 0;
  localparam int Y_AND  = 1;
  localparam int Y_OR   = 2;
  localparam int Y_NAND = 3;
  localparam int Y_NOR  = 4;
  localparam int Y_XOR  = 5;
  localparam int Y_XNOR = 6;

  // Indexed by vector {a,b}
  localparam logic [Y_W-1:0] GOLDEN [4] = '{7'h59, 7'h2D, 7'h2C, 7'h46};

  typedef struct packed {
    logic           pass;
    logic           fail_seen;
    logic [1:0]     first_fail_idx;
    logic [Y_W-1:0] fail_mask;
  } result_t;

endpackage

// File: rtl/logicgates_bist_if.sv
// Stimulus/response and result bundle between the BIST sequencer and its user.
interface logicgates_bist_if;
  import logicgates_pkg::*;

  logic           start;
  logic [Y_W-1:0] y_in;
  logic           a_out;
  logic           b_out;
  logic           busy;
  logic           done;
  logic           pass;
  logic [Y_W-1:0] fail_mask;
  logic [1:0]     first_fail_idx;
  logic           fail_seen;

  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, fail_mask, first_fail_idx, fail_seen
  );

  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, fail_mask, first_fail_idx, fail_seen
  );

endinterface

// File: rtl/logicgates_bist_golden.sv
// Expected gate-unit response for vector {a,b}, built from the gate equations
// rather than the lookup table so either one catches a typo in the other.
module logicgates_golden
  import logicgates_pkg::*;
(
  input  logic [1:0]     i_idx,
  output logic [Y_W-1:0] o_y
);

  logic w_a, w_b;
  assign w_a = i_idx[1];
  assign w_b = i_idx[0];

  always_comb begin
    o_y         = '0;
    o_y[Y_NOT]  = ~w_a;
    o_y[Y_AND]  = w_a & w_b;
    o_y[Y_OR]   = w_a | w_b;
    o_y[Y_NAND] = ~(w_a & w_b);
    o_y[Y_NOR]  = ~(w_a | w_b);
    o_y[Y_XOR]  = w_a ^ w_b;
    o_y[Y_XNOR] = ~(w_a ^ w_b);
  end

endmodule

// File: rtl/logicgates_bist.sv
// Self-test sequencer: walks {a,b} through 00..11, waits SETTLE_CYCLES per
// vector, samples y and accumulates a sticky mismatch mask and first-fail index.
module logicgates_bist
  import logicgates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  logicgates_bist_if.slave bus
);

  if (SETTLE_CYCLES < 1) begin : g_param_chk
    $error("logicgates_bist: SETTLE_CYCLES must be >= 1");
  end

  localparam int              CW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE_CYCLES - 1);

  state_e         r_state, w_state_n;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_idx;
  result_t        r_res;
  logic [Y_W-1:0] w_exp, w_mism;
  logic           w_start_acc, w_sample;

  logicgates_golden u_golden (
    .i_idx (r_idx),
    .o_y   (w_exp)
  );

  assign w_mism = bus.y_in ^ w_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_start_acc = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_n   = ST_SETTLE;
        end
      end
      ST_SETTLE: if (r_cnt == '0) w_state_n = ST_SAMPLE;
      ST_SAMPLE: begin
        w_sample  = 1'b1;
        w_state_n = (r_idx == 2'd3) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE:  w_state_n = ST_IDLE;
      default:  w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_res <= '0;
    end else if (w_start_acc) begin
      r_cnt <= RELOAD;
      r_idx <= '0;
      r_res <= '0;
    end else if (r_state == ST_SETTLE && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (w_sample) begin
      r_res.fail_mask <= r_res.fail_mask | w_mism;
      if ((|w_mism) && !r_res.fail_seen) begin
        r_res.first_fail_idx <= r_idx;
        r_res.fail_seen      <= 1'b1;
      end
      // Last vector: pass must include this sample, so it cannot use fail_seen alone
      if (r_idx != 2'd3) begin
        r_idx <= r_idx + 2'd1;
        r_cnt <= RELOAD;
      end else begin
        r_res.pass <= ~(r_res.fail_seen | (|w_mism));
      end
    end
  end

  assign bus.a_out          = r_idx[1];
  assign bus.b_out          = r_idx[0];
  assign bus.busy           = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign bus.done           = (r_state == ST_DONE);
  assign bus.pass           = r_res.pass;
  assign bus.fail_mask      = r_res.fail_mask;
  assign bus.first_fail_idx = r_res.first_fail_idx;
  assign bus.fail_seen      = r_res.fail_seen;

  golden_xcheck: assert property (@(posedge clk) disable iff (!rst_n) w_exp == GOLDEN[r_idx]);

endmodule

// File: tb/tb_logicgates_bist.sv
// Bench for logicgates_bist: two instances (settle 2 and 4) driven by a
// behavioural gate model with injectable per-vector error patterns.
module tb_logicgates_bist;
  import logicgates_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logicgates_bist_if bus0 ();
  logicgates_bist_if bus1 ();

  logicgates_bist #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  logicgates_bist #(.SETTLE_CYCLES(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] err0 [4];
  logic [6:0] err1 [4];
  logic       glitch0 = 1'b0, glitch1 = 1'b0;

  function automatic logic [6:0] truth(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
  endfunction

  always_comb bus0.y_in = truth(bus0.a_out, bus0.b_out) ^ err0[{bus0.a_out, bus0.b_out}] ^ (glitch0 ? 7'h7F : 7'h00);
  always_comb bus1.y_in = truth(bus1.a_out, bus1.b_out) ^ err1[{bus1.a_out, bus1.b_out}] ^ (glitch1 ? 7'h7F : 7'h00);

  // observations from the last run
  int         o_done_k, o_done_cnt, o_busy_cnt, o_ab_err;
  logic       o_pass, o_fseen, o_pass0, o_fseen0;
  logic [6:0] o_mask, o_mask0;
  logic [1:0] o_fidx;

  task automatic set_start(input int d, input logic v);
    if (d == 0) bus0.start = v; else bus1.start = v;
  endtask

  task automatic set_glitch(input int d, input logic v);
    if (d == 0) glitch0 = v; else glitch1 = v;
  endtask

  task automatic set_err(input int d, input int i, input logic [6:0] v);
    if (d == 0) err0[i] = v; else err1[i] = v;
  endtask

  task automatic peek(input int d, output logic dn, output logic bz, output logic [1:0] ab,
                      output logic ps, output logic fs, output logic [6:0] m, output logic [1:0] fi);
    if (d == 0) begin
      dn = bus0.done; bz = bus0.busy; ab = {bus0.a_out, bus0.b_out};
      ps = bus0.pass; fs = bus0.fail_seen; m = bus0.fail_mask; fi = bus0.first_fail_idx;
    end else begin
      dn = bus1.done; bz = bus1.busy; ab = {bus1.a_out, bus1.b_out};
      ps = bus1.pass; fs = bus1.fail_seen; m = bus1.fail_mask; fi = bus1.first_fail_idx;
    end
  endtask

  task automatic run_obs(input int d, input int extra_k, input bit do_glitch);
    int p, l;
    logic dn, bz, ps, fs;
    logic [1:0] ab, fi;
    logic [6:0] m;
    p = (d == 0) ? 3 : 5;
    l = 4 * p;
    o_done_k = -1; o_done_cnt = 0; o_busy_cnt = 0; o_ab_err = 0;
    o_pass = 1'bx; o_fseen = 1'bx; o_mask = 'x; o_fidx = 'x;
    @(negedge clk) set_start(d, 1'b1);
    @(negedge clk) set_start(d, 1'b0);
    for (int k = 0; k <= l + 4; k++) begin
      if (k > 0) @(negedge clk);
      set_glitch(d, 1'b0);
      peek(d, dn, bz, ab, ps, fs, m, fi);
      if (k == 0) begin o_mask0 = m; o_pass0 = ps; o_fseen0 = fs; end
      if (k < l && ab !== 2'(k / p)) o_ab_err++;
      if (bz) o_busy_cnt++;
      if (dn) begin
        o_done_cnt++;
        if (o_done_k < 0) begin
          o_done_k = k; o_pass = ps; o_fseen = fs; o_mask = m; o_fidx = fi;
        end
      end
      set_start(d, (k == extra_k) ? 1'b1 : 1'b0);
      if (do_glitch && (k % p) == 2 && k < l) set_glitch(d, 1'b1);
    end
    set_start(d, 1'b0);
  endtask

  task automatic clear_err();
    for (int i = 0; i < 4; i++) begin err0[i] = '0; err1[i] = '0; end
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if ({bus0.a_out, bus0.b_out, bus0.busy, bus0.done, bus0.pass, bus0.fail_mask, bus0.first_fail_idx, bus0.fail_seen} !== 15'h0) begin
      n_fail++; $display("FAIL reset_dut0 got a%b b%b busy%b done%b pass%b mask%h fidx%0d fs%b expected all zero", bus0.a_out, bus0.b_out, bus0.busy, bus0.done, bus0.pass, bus0.fail_mask, bus0.first_fail_idx, bus0.fail_seen); end
    n_tests++; if ({bus1.a_out, bus1.b_out, bus1.busy, bus1.done, bus1.pass, bus1.fail_mask, bus1.first_fail_idx, bus1.fail_seen} !== 15'h0) begin
      n_fail++; $display("FAIL reset_dut1 got busy%b done%b pass%b mask%h expected all zero", bus1.busy, bus1.done, bus1.pass, bus1.fail_mask); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b expected 0/0", bus0.busy, bus0.done); end
  endtask

  task automatic test_clean();
    clear_err();
    run_obs(0, -1, 1'b0);
    n_tests++; if (o_done_k != 12) begin n_fail++; $display("FAIL clean_done_time got %0d expected 12", o_done_k); end
    n_tests++; if (o_done_cnt != 1) begin n_fail++; $display("FAIL clean_done_count got %0d expected 1", o_done_cnt); end
    n_tests++; if (o_busy_cnt != 12) begin n_fail++; $display("FAIL clean_busy_cycles got %0d expected 12", o_busy_cnt); end
    n_tests++; if (o_ab_err != 0) begin n_fail++; $display("FAIL clean_ab_sequence got %0d bad cycles expected 0", o_ab_err); end
    n_tests++; if ({o_pass, o_fseen, o_mask} !== {1'b1, 1'b0, 7'h00}) begin
      n_fail++; $display("FAIL clean_result got pass=%b fs=%b mask=%h expected 1/0/00", o_pass, o_fseen, o_mask); end
    n_tests++; if ({bus0.a_out, bus0.b_out} !== 2'b11) begin
      n_fail++; $display("FAIL ab_hold_after_run got %b%b expected 11", bus0.a_out, bus0.b_out); end
  endtask

  task automatic test_xor_stuck();
    clear_err();
    for (int i = 0; i < 4; i++) err0[i] = truth(i[1], i[0]) & 7'h20;
    run_obs(0, -1, 1'b0);
    n_tests++; if ({o_pass, o_fseen, o_mask, o_fidx} !== {1'b0, 1'b1, 7'h20, 2'd1}) begin
      n_fail++; $display("FAIL xor_stuck got pass=%b fs=%b mask=%h fidx=%0d expected 0/1/20/1", o_pass, o_fseen, o_mask, o_fidx); end
  endtask

  task automatic test_clear_after_fail();
    clear_err();
    run_obs(0, -1, 1'b0);
    n_tests++; if ({o_pass0, o_fseen0, o_mask0} !== 9'h0) begin
      n_fail++; $display("FAIL clear_on_start got pass=%b fs=%b mask=%h expected 0/0/00", o_pass0, o_fseen0, o_mask0); end
    n_tests++; if ({o_pass, o_mask, o_fidx} !== {1'b1, 7'h00, 2'd0}) begin
      n_fail++; $display("FAIL clean_after_fail got pass=%b mask=%h fidx=%0d expected 1/00/0", o_pass, o_mask, o_fidx); end
  endtask

  task automatic test_and_as_or();
    clear_err();
    for (int i = 0; i < 4; i++) err0[i] = {5'b0, (i[1] | i[0]) ^ (i[1] & i[0]), 1'b0};
    run_obs(0, -1, 1'b0);
    n_tests++; if ({o_pass, o_mask, o_fidx} !== {1'b0, 7'h02, 2'd1}) begin
      n_fail++; $display("FAIL and_as_or got pass=%b mask=%h fidx=%0d expected 0/02/1", o_pass, o_mask, o_fidx); end
  endtask

  task automatic test_back_to_back();
    clear_err();
    run_obs(0, 5, 1'b0);
    n_tests++; if (o_done_cnt != 1 || o_done_k != 12) begin
      n_fail++; $display("FAIL start_while_busy got %0d dones at k=%0d expected 1 at 12", o_done_cnt, o_done_k); end
  endtask

  task automatic test_start_held();
    int first_k, second_k, cnt;
    first_k = -1; second_k = -1; cnt = 0;
    clear_err();
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (bus0.done) begin
        cnt++;
        if (first_k < 0) first_k = k; else if (second_k < 0) second_k = k;
      end
    end
    bus0.start = 1'b0;
    repeat (16) @(negedge clk);
    n_tests++; if (first_k != 12 || second_k != 26 || cnt != 2) begin
      n_fail++; $display("FAIL start_held got dones=%0d at %0d,%0d expected 2 at 12,26", cnt, first_k, second_k); end
  endtask

  task automatic test_reset_midrun();
    int dones;
    clear_err();
    for (int i = 0; i < 4; i++) err0[i] = truth(i[1], i[0]) & 7'h20;
    dones = 0;
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk) bus0.start = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++; if (bus0.fail_seen !== 1'b1) begin n_fail++; $display("FAIL midrun_pre_reset got fs=%b expected 1", bus0.fail_seen); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({bus0.a_out, bus0.b_out, bus0.busy, bus0.done, bus0.pass, bus0.fail_mask, bus0.first_fail_idx, bus0.fail_seen} !== 15'h0) begin
      n_fail++; $display("FAIL midrun_reset got a%b b%b busy%b mask%h fidx%0d fs%b expected all zero", bus0.a_out, bus0.b_out, bus0.busy, bus0.fail_mask, bus0.first_fail_idx, bus0.fail_seen); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus0.done) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL midrun_no_done got %0d dones expected 0", dones); end
    clear_err();
    run_obs(0, -1, 1'b0);
    n_tests++; if (o_pass !== 1'b1 || o_done_k != 12) begin
      n_fail++; $display("FAIL run_after_reset got pass=%b done_k=%0d expected 1/12", o_pass, o_done_k); end
  endtask

  task automatic test_settle4();
    clear_err();
    run_obs(1, -1, 1'b1);
    n_tests++; if (o_done_k != 20 || o_done_cnt != 1) begin
      n_fail++; $display("FAIL settle4_done got %0d dones at k=%0d expected 1 at 20", o_done_cnt, o_done_k); end
    n_tests++; if (o_busy_cnt != 20 || o_ab_err != 0) begin
      n_fail++; $display("FAIL settle4_hold got busy=%0d ab_bad=%0d expected 20/0", o_busy_cnt, o_ab_err); end
    n_tests++; if ({o_pass, o_mask} !== {1'b1, 7'h00}) begin
      n_fail++; $display("FAIL settle4_glitch got pass=%b mask=%h expected 1/00", o_pass, o_mask); end
  endtask

  task automatic test_random();
    logic [6:0] e [4];
    logic [6:0] exp_mask;
    logic [1:0] exp_fidx;
    bit         found;
    int         d;
    for (int it = 0; it < 10; it++) begin
      d = it % 2;
      clear_err();
      exp_mask = '0; exp_fidx = '0; found = 0;
      for (int i = 0; i < 4; i++) begin
        e[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'h00;
        set_err(d, i, e[i]);
        exp_mask |= e[i];
        if (!found && e[i] != 0) begin found = 1; exp_fidx = 2'(i); end
      end
      run_obs(d, -1, 1'b0);
      n_tests++; if ({o_pass, o_fseen, o_mask, o_fidx} !== {~found, found, exp_mask, exp_fidx} || o_done_k != 4 * (d == 0 ? 3 : 5)) begin
        n_fail++; $display("FAIL random_%0d dut%0d got pass=%b fs=%b mask=%h fidx=%0d k=%0d expected %b/%b/%h/%0d", it, d, o_pass, o_fseen, o_mask, o_fidx, o_done_k, ~found, found, exp_mask, exp_fidx); end
    end
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    clear_err();
    test_reset();
    test_clean();
    test_xor_stuck();
    test_clear_after_fail();
    test_and_as_or();
    test_back_to_back();
    test_start_held();
    test_reset_midrun();
    test_settle4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
